// File: rtl/rf_scoreboard.sv
// Register file with a per-register pending-writer scoreboard for an in-order decode stage.
// Counts outstanding writers per destination, raises busy/stall for consumed operands, optional writeback bypass.
module rf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              use1,
    input  logic              use2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              iss_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

    localparam int                NREG = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PMAX = '1;
    localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);

    logic [DATA_W-1:0] regs    [NREG];
    logic [PEND_W-1:0] cnt     [NREG];
    logic [PEND_W-1:0] cnt_nxt [NREG];

    logic            wb_write;
    logic            iss_acc;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    assign wb_write  = wb_en && (wb_addr != '0);
    assign iss_ready = (iss_dst == '0) || (cnt[iss_dst] != PMAX);
    assign iss_acc   = iss_valid && iss_ready && !flush;

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0)
            return '0;
        else if (BYPASS != 0 && wb_en && wb_addr == ra)
            return wb_data;
        else
            return regs[ra];
    endfunction

    // A writer retiring this very cycle clears busy only when it is the last one outstanding.
    function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0 || cnt[ra] == '0)
            return 1'b0;
        else if (BYPASS != 0 && wb_en && wb_addr == ra && cnt[ra] == ONE)
            return 1'b0;
        else
            return 1'b1;
    endfunction

    assign rd1   = read_port(ra1);
    assign rd2   = read_port(ra2);
    assign busy1 = busy_port(ra1);
    assign busy2 = busy_port(ra2);
    assign stall = (use1 && busy1) || (use2 && busy2);

    // NOTE: every variable in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_acc && iss_dst != '0)
            inc_vec[iss_dst] = 1'b1;
        if (wb_write)
            dec_vec[wb_addr] = 1'b1;

        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (flush)
                cnt_nxt[r] = '0;
            else if (inc_vec[r] && !dec_vec[r])
                cnt_nxt[r] = cnt[r] + ONE;
            else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                cnt_nxt[r] = cnt[r] - ONE;
        end
    end

    // NOTE: the register array is reset on purpose (reads after reset must be 0), so it is
    // built from flops rather than a RAM macro; a plain RAM would be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
            if (wb_write)
                regs[wb_addr] <= wb_data;
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard: one bypassing and one non-bypassing
// instance share all inputs; expected values are hand-computed constants.
module tb_rf_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] ra1, ra2;
    logic              use1, use2;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dst;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;

    logic [DATA_W-1:0] rd1, rd2, nb_rd1, nb_rd2;
    logic              busy1, busy2, stall, iss_ready;
    logic              nb_busy1, nb_busy2, nb_stall, nb_iss_ready;

    int n_checks = 0;
    int n_fail   = 0;

    rf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
        .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2), .stall(stall),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    rf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
        .rd1(nb_rd1), .rd2(nb_rd2), .busy1(nb_busy1), .busy2(nb_busy2), .stall(nb_stall),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(nb_iss_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_dst = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        ra1 = '0; ra2 = '0; use1 = 1'b0; use2 = 1'b0;
        idle_inputs();

        // Issue and writeback to r5 presented while in reset must be ignored.
        iss_valid = 1'b1; iss_dst = 5'd5;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAAAA_AAAA;
        ra1 = 5'd5; use1 = 1'b1;
        #1;
        check("reset_iss_ready", iss_ready, 1);
        check("reset_stall", stall, 0);
        tick();
        idle_inputs();
        #1;
        reset = 1'b1;
        #1;
        check("post_reset_rd1", rd1, 0);
        check("post_reset_busy1", busy1, 0);
        check("post_reset_stall", stall, 0);

        // Issue r5, then consume it, then bypass the writeback.
        iss_valid = 1'b1; iss_dst = 5'd5;
        #1;
        check("r5_iss_ready", iss_ready, 1);
        tick();
        idle_inputs();
        #1;
        check("r5_busy1", busy1, 1);
        check("r5_stall", stall, 1);
        check("r5_nb_busy1", nb_busy1, 1);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        check("r5_bypass_rd1", rd1, 32'hDEAD_BEEF);
        check("r5_bypass_busy1", busy1, 0);
        check("r5_bypass_stall", stall, 0);
        check("r5_nb_rd1_old", nb_rd1, 0);
        check("r5_nb_busy1_wb", nb_busy1, 1);
        check("r5_nb_stall_wb", nb_stall, 1);
        tick();
        idle_inputs();
        #1;
        check("r5_rd1_after_wb", rd1, 32'hDEAD_BEEF);
        check("r5_nb_rd1_after_wb", nb_rd1, 32'hDEAD_BEEF);
        check("r5_busy1_after_wb", busy1, 0);
        check("r5_nb_busy1_after_wb", nb_busy1, 0);
        use1 = 1'b0;

        // Saturate r7 at PMAX=3, a fourth issue is refused, then drain.
        ra2 = 5'd7; use2 = 1'b1;
        iss_valid = 1'b1; iss_dst = 5'd7;
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("r7_full_iss_ready", iss_ready, 0);
        check("r7_full_busy2", busy2, 1);
        tick();
        idle_inputs();
        wb_en = 1'b1; wb_addr = 5'd7;
        for (int i = 0; i < 2; i++) begin
            wb_data = 32'h70 + i;
            tick();
        end
        wb_en = 1'b0;
        #1;
        check("r7_cnt1_busy2", busy2, 1);
        check("r7_cnt1_stall", stall, 1);
        check("r7_cnt1_rd2", rd2, 32'h71);
        wb_en = 1'b1; wb_data = 32'h72;
        tick();
        idle_inputs();
        iss_dst = 5'd7;
        #1;
        check("r7_drained_busy2", busy2, 0);
        check("r7_drained_nb_busy2", nb_busy2, 0);
        check("r7_drained_iss_ready", iss_ready, 1);
        check("r7_drained_rd2", rd2, 32'h72);
        idle_inputs();
        use2 = 1'b0;

        // Same-cycle issue and writeback to r3 with cnt=1 nets to zero.
        iss_valid = 1'b1; iss_dst = 5'd3;
        tick();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h12;
        tick();
        idle_inputs();
        ra1 = 5'd3; use1 = 1'b1;
        #1;
        check("r3_busy1_kept", busy1, 1);
        check("r3_rd1", rd1, 32'h12);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h13;
        tick();
        idle_inputs();
        #1;
        check("r3_cleared_busy1", busy1, 0);
        use1 = 1'b0;

        // Flush overrides a simultaneous issue to r4 and decrement of r9; r9 data still written.
        iss_valid = 1'b1; iss_dst = 5'd4;
        tick();
        tick();
        iss_dst = 5'd9;
        tick();
        flush = 1'b1; iss_dst = 5'd4;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        tick();
        idle_inputs();
        ra1 = 5'd4; use1 = 1'b1;
        ra2 = 5'd9; use2 = 1'b1;
        iss_dst = 5'd4;
        #1;
        check("flush_busy1_r4", busy1, 0);
        check("flush_busy2_r9", busy2, 0);
        check("flush_stall", stall, 0);
        check("flush_rd2_r9", rd2, 32'h55);
        check("flush_iss_ready_r4", iss_ready, 1);

        // Register 0 is never written nor reserved, and never stalls.
        idle_inputs();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        iss_valid = 1'b1; iss_dst = 5'd0;
        ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("r0_iss_ready", iss_ready, 1);
        check("r0_rd1_during_wb", rd1, 0);
        tick();
        idle_inputs();
        #1;
        check("r0_rd1", rd1, 0);
        check("r0_busy1", busy1, 0);
        check("r0_stall", stall, 0);

        // Issue r10 and writeback r5 in one cycle act independently.
        iss_valid = 1'b1; iss_dst = 5'd10;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h77;
        tick();
        idle_inputs();
        ra1 = 5'd10; ra2 = 5'd5;
        #1;
        check("indep_busy1_r10", busy1, 1);
        check("indep_rd2_r5", rd2, 32'h77);
        check("indep_busy2_r5", busy2, 0);
        check("indep_stall", stall, 1);

        // Asynchronous reset mid-cycle with a pending count on r10.
        iss_dst = 5'd10;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rd2", rd2, 0);
        check("async_rst_busy1", busy1, 0);
        check("async_rst_stall", stall, 0);
        check("async_rst_iss_ready", iss_ready, 1);
        #1;
        reset = 1'b1;
        tick();
        check("after_rst_busy1", busy1, 0);
        check("after_rst_rd2", rd2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
